// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral in front of a small register file. It takes write and
// read-back frames {rw, addr, data}, sent MSB first, and counts rejected frames.
//
// state  | meaning
// IDLE   | waiting for ncs to fall
// ADDR   | shifting in the rw bit and the address
// DATA   | shifting in data; read data goes out on cipo
// COMMIT | one cycle to judge the frame: write, count an error, or do nothing
module spi_regfile_rw #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q;
  logic                   sclk_d, ncs_d;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   sclk_s, copi_s, ncs_s, armed;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic [1:0]         state;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sout;

  logic               frm_rw, hdr_rw, addr_ok, wr_ok, frm_err;
  logic [ADDR_W-1:0]  frm_addr, hdr_addr, look_addr;
  logic [DATA_W-1:0]  frm_data, rd_data;

  // ncs resets to "deasserted". The arm pipeline keeps the reset value from
  // looking like a falling edge when ncs is already low as reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '1;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
      arm_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
      ncs_q  <= {ncs_q[SYNC_STAGES-2:0], ncs};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      ncs_d  <= ncs_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_q[SYNC_STAGES-1];
  assign armed     = arm_q[SYNC_STAGES];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_fall  = armed & ncs_d & ~ncs_s;
  assign ncs_rise  = armed & ~ncs_d & ncs_s;
  assign cipo_oe   = ~ncs_s;

  assign frm_rw    = shift_q[FRAME_W-1];
  assign frm_addr  = shift_q[DATA_W +: ADDR_W];
  assign frm_data  = shift_q[DATA_W-1:0];
  assign hdr_rw    = shift_q[ADDR_W];
  assign hdr_addr  = shift_q[ADDR_W-1:0];
  assign look_addr = (state == COMMIT) ? frm_addr : hdr_addr;

  // Register lookup. An address with no register returns zero and is not valid.
  always_comb begin
    rd_data = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (look_addr == ADDR_W'(i)) begin
        rd_data = regs_flat[i*DATA_W +: DATA_W];
        addr_ok = 1'b1;
      end
    end
  end

  assign wr_ok   = (cnt == CNT_FRAME) && frm_rw && addr_ok;
  assign frm_err = (cnt != CNT_FRAME) || !addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt       <= '0;
      sout      <= '0;
      cipo      <= 1'b0;
      regs_flat <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_cnt   <= '0;
    end else begin
      wr_strobe <= 1'b0;

      if (sclk_rise && !ncs_s && (state == ADDR || state == DATA)) begin
        shift_q <= {shift_q[FRAME_W-2:0], copi_s};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end

      // The falling edge right after the last address bit must not shift,
      // because the data MSB is sampled on the next rising edge.
      if (sclk_fall && state == DATA && cnt > CNT_HDR) begin
        cipo <= sout[DATA_W-1];
        sout <= sout << 1;
      end

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= ADDR;
            shift_q <= '0;
            cnt     <= '0;
          end
        end
        ADDR: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (cnt == CNT_HDR) begin
            state <= DATA;
            if (!hdr_rw) begin
              cipo <= rd_data[DATA_W-1];
              sout <= rd_data << 1;
            end else begin
              cipo <= 1'b0;
              sout <= '0;
            end
          end
        end
        DATA: begin
          if (ncs_rise) state <= COMMIT;
        end
        default: begin
          if (wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (frm_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= frm_data;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= frm_addr;
          end
          if (frm_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (ncs_fall) begin
            state   <= ADDR;
            shift_q <= '0;
            cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (ncs_s) begin
        cipo <= 1'b0;
        sout <= '0;
      end
    end
  end

endmodule
